// File: rtl/alu_ref_scoreboard.sv
// In-order reference scoreboard for the ALU: predicts each issued op's result and branch outcome,
// queues the prediction and compares it against the DUT response whenever the DUT reports a result.
module alu_ref_scoreboard #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [3:0]       op_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic             dut_valid_i,
    input  logic [XLEN-1:0]  dut_result_i,
    input  logic             dut_branch_res_i,
    output logic             mismatch_o,
    output logic             err_sticky_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic [CNT_W-1:0] check_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [XLEN-1:0]  exp_result_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = XLEN + 2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_EQ   = 4'd5;
    localparam logic [3:0] OP_NE   = 4'd6;
    localparam logic [3:0] OP_SLTS = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    logic             mismatch_q, mismatch_d;
    logic             err_sticky_q, err_sticky_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [XLEN-1:0]  exp_result_q, exp_result_d;

    logic             ref_chk;
    logic [XLEN-1:0]  ref_result;
    logic             ref_branch;
    logic             cmp;

    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [ENT_W-1:0] pop_entry;
    logic             pop_chk;
    logic [XLEN-1:0]  pop_result;
    logic             pop_branch;

    always_comb begin
        ref_chk    = 1'b1;
        ref_result = '0;
        ref_branch = 1'b0;
        cmp        = 1'b0;
        case (op_i)
            OP_ADD:  ref_result = operand_a_i + operand_b_i;
            OP_SUB:  ref_result = operand_a_i - operand_b_i;
            OP_AND:  ref_result = operand_a_i & operand_b_i;
            OP_OR:   ref_result = operand_a_i | operand_b_i;
            OP_XOR:  ref_result = operand_a_i ^ operand_b_i;
            OP_EQ:   cmp = (operand_a_i == operand_b_i);
            OP_NE:   cmp = (operand_a_i != operand_b_i);
            OP_SLTS: cmp = ($signed(operand_a_i) < $signed(operand_b_i));
            OP_SLTU: cmp = (operand_a_i < operand_b_i);
            default: ref_chk = 1'b0;
        endcase
        if (op_i inside {OP_EQ, OP_NE, OP_SLTS, OP_SLTU}) begin
            ref_result = {{(XLEN-1){1'b0}}, cmp};
            ref_branch = cmp;
        end
    end

    // Full/empty use the extra pointer MSB so all DEPTH slots are usable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop  = dut_valid_i && !fifo_empty && !flush_i;
    assign push = valid_i && !flush_i && (!fifo_full || pop);

    assign pop_entry  = mem_q[rd_ptr_q[AW-1:0]];
    assign pop_chk    = pop_entry[ENT_W-1];
    assign pop_result = pop_entry[XLEN:1];
    assign pop_branch = pop_entry[0];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mismatch_d   = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        check_cnt_d  = check_cnt_q;
        err_cnt_d    = err_cnt_q;
        exp_result_d = exp_result_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            overflow_d  = valid_i && fifo_full && !dut_valid_i;
            underflow_d = dut_valid_i && fifo_empty;
            // Entries of unsupported ops are popped silently to keep the stream aligned.
            if (pop && pop_chk) begin
                mismatch_d   = (pop_result != dut_result_i) || (pop_branch != dut_branch_res_i);
                exp_result_d = pop_result;
                if (check_cnt_q != {CNT_W{1'b1}}) check_cnt_d = check_cnt_q + 1'b1;
                if (mismatch_d && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        err_sticky_d = err_sticky_q || mismatch_d || overflow_d || underflow_d;
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) mem_q[wr_ptr_q[AW-1:0]] <= {ref_chk, ref_result, ref_branch};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            check_cnt_q  <= '0;
            err_cnt_q    <= '0;
            exp_result_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mismatch_q   <= mismatch_d;
            err_sticky_q <= err_sticky_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            check_cnt_q  <= check_cnt_d;
            err_cnt_q    <= err_cnt_d;
            exp_result_q <= exp_result_d;
        end
    end

    assign mismatch_o   = mismatch_q;
    assign err_sticky_o = err_sticky_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;
    assign check_cnt_o  = check_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign exp_result_o = exp_result_q;

endmodule

// File: tb/tb_alu_ref_scoreboard.sv
// Directed bench for alu_ref_scoreboard: hand-computed issue/return sequences, compared after each edge.
module tb_alu_ref_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, dut_valid_i, dut_branch_res_i;
    logic [3:0]  op_i;
    logic [63:0] operand_a_i, operand_b_i, dut_result_i;
    logic        mismatch_o, err_sticky_o, overflow_o, underflow_o;
    logic [15:0] check_cnt_o, err_cnt_o;
    logic [63:0] exp_result_o;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk_i = ~clk_i;

    alu_ref_scoreboard #(.XLEN(64), .DEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .dut_valid_i(dut_valid_i),
        .dut_result_i(dut_result_i), .dut_branch_res_i(dut_branch_res_i),
        .mismatch_o(mismatch_o), .err_sticky_o(err_sticky_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .check_cnt_o(check_cnt_o), .err_cnt_o(err_cnt_o),
        .exp_result_o(exp_result_o)
    );

    // Drives one cycle of inputs, then waits until just after the edge that samples them.
    task automatic applyStimulus(input logic rst, input logic flush, input logic v,
                                 input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic dv, input logic [63:0] dres, input logic dbr);
        rst_i = rst; flush_i = flush; valid_i = v; op_i = op;
        operand_a_i = a; operand_b_i = b;
        dut_valid_i = dv; dut_result_i = dres; dut_branch_res_i = dbr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        applyStimulus(0, 0, 1, op, a, b, 0, 64'd0, 0);
    endtask

    task automatic dutReturn(input logic [63:0] res, input logic br);
        applyStimulus(0, 0, 0, 4'd0, 64'd0, 64'd0, 1, res, br);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 4'd0, 64'd0, 64'd0, 0, 64'd0, 0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 4'd0, 64'd0, 64'd0, 0, 64'd0, 0);
        applyStimulus(1, 0, 0, 4'd0, 64'd0, 64'd0, 0, 64'd0, 0);
        checkOutput("rst_mismatch", {63'd0, mismatch_o}, 64'd0);
        checkOutput("rst_sticky", {63'd0, err_sticky_o}, 64'd0);
        checkOutput("rst_overflow", {63'd0, overflow_o}, 64'd0);
        checkOutput("rst_underflow", {63'd0, underflow_o}, 64'd0);
        checkOutput("rst_check_cnt", {48'd0, check_cnt_o}, 64'd0);
        checkOutput("rst_err_cnt", {48'd0, err_cnt_o}, 64'd0);
        checkOutput("rst_exp_result", exp_result_o, 64'd0);

        // ADD with wraparound, DUT answers two cycles later
        issue(4'd0, ALL1, 64'd1);
        idle();
        dutReturn(64'd0, 0);
        checkOutput("add_mismatch", {63'd0, mismatch_o}, 64'd0);
        checkOutput("add_check_cnt", {48'd0, check_cnt_o}, 64'd1);

        // SUB negative result, then a deliberately wrong DUT answer
        issue(4'd1, 64'd5, 64'd7);
        dutReturn(64'hFFFF_FFFF_FFFF_FFFE, 0);
        checkOutput("sub_ok_mismatch", {63'd0, mismatch_o}, 64'd0);
        checkOutput("sub_ok_sticky", {63'd0, err_sticky_o}, 64'd0);
        issue(4'd1, 64'd5, 64'd7);
        dutReturn(64'd2, 0);
        checkOutput("sub_bad_mismatch", {63'd0, mismatch_o}, 64'd1);
        checkOutput("sub_bad_err_cnt", {48'd0, err_cnt_o}, 64'd1);
        checkOutput("sub_bad_sticky", {63'd0, err_sticky_o}, 64'd1);
        checkOutput("sub_bad_exp", exp_result_o, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("sub_bad_check_cnt", {48'd0, check_cnt_o}, 64'd3);
        idle();
        checkOutput("mismatch_pulse_low", {63'd0, mismatch_o}, 64'd0);

        // Compares: EQ, SLTS, SLTU with branch outcomes
        issue(4'd5, 64'h1234, 64'h1234);
        issue(4'd7, ALL1, 64'd0);
        issue(4'd8, ALL1, 64'd0);
        dutReturn(64'd1, 1);
        checkOutput("eq_mismatch", {63'd0, mismatch_o}, 64'd0);
        dutReturn(64'd1, 1);
        checkOutput("slts_mismatch", {63'd0, mismatch_o}, 64'd0);
        checkOutput("slts_exp", exp_result_o, 64'd1);
        dutReturn(64'd0, 0);
        checkOutput("sltu_mismatch", {63'd0, mismatch_o}, 64'd0);
        checkOutput("sltu_exp", exp_result_o, 64'd0);
        checkOutput("cmp_check_cnt", {48'd0, check_cnt_o}, 64'd6);

        // NE branch mismatch only (result right, branch wrong)
        issue(4'd6, 64'd3, 64'd4);
        dutReturn(64'd1, 0);
        checkOutput("ne_branch_mismatch", {63'd0, mismatch_o}, 64'd1);
        checkOutput("ne_err_cnt", {48'd0, err_cnt_o}, 64'd2);
        checkOutput("ne_check_cnt", {48'd0, check_cnt_o}, 64'd7);

        // Unsupported op: popped without compare
        issue(4'd9, 64'd1, 64'd2);
        dutReturn(64'hDEAD, 1);
        checkOutput("unsup_mismatch", {63'd0, mismatch_o}, 64'd0);
        checkOutput("unsup_check_cnt", {48'd0, check_cnt_o}, 64'd7);
        checkOutput("unsup_exp_kept", exp_result_o, 64'd1);

        // Overflow on the fifth back-to-back issue
        for (int i = 1; i <= 5; i++) begin
            issue(4'd0, 64'(i), 64'd10);
            checkOutput("ovf_pulse", {63'd0, overflow_o}, (i == 5) ? 64'd1 : 64'd0);
        end
        idle();
        checkOutput("ovf_pulse_low", {63'd0, overflow_o}, 64'd0);
        for (int i = 1; i <= 4; i++) begin
            dutReturn(64'(10 + i), 0);
            checkOutput("ovf_drain_mismatch", {63'd0, mismatch_o}, 64'd0);
        end
        checkOutput("ovf_drain_cnt", {48'd0, check_cnt_o}, 64'd11);
        dutReturn(64'd15, 0);
        checkOutput("udf_pulse", {63'd0, underflow_o}, 64'd1);
        checkOutput("udf_no_count", {48'd0, check_cnt_o}, 64'd11);
        checkOutput("udf_no_mismatch", {63'd0, mismatch_o}, 64'd0);

        // Full FIFO with simultaneous push and pop keeps order and occupancy
        for (int i = 1; i <= 4; i++) issue(4'd4, 64'(i), 64'hF0);
        applyStimulus(0, 0, 1, 4'd3, 64'h100, 64'h3, 1, 64'hF1, 0);
        checkOutput("full_pp_overflow", {63'd0, overflow_o}, 64'd0);
        checkOutput("full_pp_mismatch", {63'd0, mismatch_o}, 64'd0);
        checkOutput("full_pp_exp", exp_result_o, 64'hF1);
        dutReturn(64'hF2, 0);
        dutReturn(64'hF3, 0);
        dutReturn(64'hF4, 0);
        checkOutput("full_pp_order", exp_result_o, 64'hF4);
        dutReturn(64'h103, 0);
        checkOutput("full_pp_last_exp", exp_result_o, 64'h103);
        checkOutput("full_pp_last_mismatch", {63'd0, mismatch_o}, 64'd0);
        dutReturn(64'd0, 0);
        checkOutput("full_pp_udf", {63'd0, underflow_o}, 64'd1);
        checkOutput("full_pp_cnt", {48'd0, check_cnt_o}, 64'd16);

        // Push and pop on empty FIFO: underflow, but the pushed entry is kept
        applyStimulus(0, 0, 1, 4'd2, 64'hFF00, 64'h0FF0, 1, 64'd0, 0);
        checkOutput("empty_pp_udf", {63'd0, underflow_o}, 64'd1);
        dutReturn(64'h0F00, 0);
        checkOutput("empty_pp_udf_low", {63'd0, underflow_o}, 64'd0);
        checkOutput("empty_pp_exp", exp_result_o, 64'h0F00);
        checkOutput("empty_pp_cnt", {48'd0, check_cnt_o}, 64'd17);

        // Flush with three outstanding, pop in flush cycle ignored
        issue(4'd0, 64'd1, 64'd1);
        issue(4'd0, 64'd2, 64'd2);
        issue(4'd0, 64'd3, 64'd3);
        applyStimulus(0, 1, 1, 4'd0, 64'd9, 64'd9, 1, 64'd0, 0);
        checkOutput("flush_udf_low", {63'd0, underflow_o}, 64'd0);
        checkOutput("flush_mismatch_low", {63'd0, mismatch_o}, 64'd0);
        checkOutput("flush_cnt_kept", {48'd0, check_cnt_o}, 64'd17);
        dutReturn(64'd2, 0);
        checkOutput("post_flush_udf", {63'd0, underflow_o}, 64'd1);
        checkOutput("post_flush_err_cnt", {48'd0, err_cnt_o}, 64'd2);
        checkOutput("post_flush_sticky", {63'd0, err_sticky_o}, 64'd1);

        // Reset mid-run wins over a concurrent issue/return
        issue(4'd0, 64'd4, 64'd4);
        applyStimulus(1, 0, 1, 4'd0, 64'd1, 64'd1, 1, 64'd0, 0);
        checkOutput("mid_rst_sticky", {63'd0, err_sticky_o}, 64'd0);
        checkOutput("mid_rst_check_cnt", {48'd0, check_cnt_o}, 64'd0);
        checkOutput("mid_rst_err_cnt", {48'd0, err_cnt_o}, 64'd0);
        checkOutput("mid_rst_exp", exp_result_o, 64'd0);
        checkOutput("mid_rst_udf", {63'd0, underflow_o}, 64'd0);
        dutReturn(64'd8, 0);
        checkOutput("after_rst_empty_udf", {63'd0, underflow_o}, 64'd1);
        checkOutput("after_rst_cnt", {48'd0, check_cnt_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
